// File: rtl/axi_lite_rr_mux_pkg.sv
// Shared constants, response encodings and index helper for the AXI4-Lite round-robin mux.
package axi_lite_rr_mux_pkg;

  localparam int ProtW = 3;
  localparam int RespW = 2;

  typedef enum logic [RespW-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axi_lite_rr_mux_if.sv
// AXI4-Lite bundle carrying N ports side by side; N=1 for the shared master port.
interface axi_lite_rr_mux_if #(
  parameter int N         = 1,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  import axi_lite_rr_mux_pkg::*;

  logic [N-1:0][AddrWidth-1:0]   aw_addr;
  logic [N-1:0][ProtW-1:0]       aw_prot;
  logic [N-1:0]                  aw_valid;
  logic [N-1:0]                  aw_ready;
  logic [N-1:0][DataWidth-1:0]   w_data;
  logic [N-1:0][DataWidth/8-1:0] w_strb;
  logic [N-1:0]                  w_valid;
  logic [N-1:0]                  w_ready;
  logic [N-1:0][RespW-1:0]       b_resp;
  logic [N-1:0]                  b_valid;
  logic [N-1:0]                  b_ready;
  logic [N-1:0][AddrWidth-1:0]   ar_addr;
  logic [N-1:0][ProtW-1:0]       ar_prot;
  logic [N-1:0]                  ar_valid;
  logic [N-1:0]                  ar_ready;
  logic [N-1:0][DataWidth-1:0]   r_data;
  logic [N-1:0][RespW-1:0]       r_resp;
  logic [N-1:0]                  r_valid;
  logic [N-1:0]                  r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );

endinterface

// File: rtl/axi_lite_rr_mux_arb.sv
// Round-robin arbiter that freezes its grant while the downstream valid is stalled.
module axi_lite_rr_arb import axi_lite_rr_mux_pkg::*; #(
  parameter int NumSlv = 2,
  parameter int IdxW   = (NumSlv > 1) ? $clog2(NumSlv) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumSlv-1:0] valid,
  input  logic              out_valid,
  input  logic              out_ready,
  output logic [IdxW-1:0]   grant,
  output logic [NumSlv-1:0] grant_oh
);
  logic [IdxW-1:0] ptr, lock_idx, search_idx;
  logic            locked;

  // Walk offsets high to low so the nearest valid requester at/after ptr wins.
  always_comb begin
    search_idx = ptr;
    for (int i = NumSlv - 1; i >= 0; i--) begin
      if (valid[(32'(ptr) + i) % NumSlv]) search_idx = IdxW'((32'(ptr) + i) % NumSlv);
    end
  end

  assign grant    = locked ? lock_idx : search_idx;
  assign grant_oh = NumSlv'(1'b1) << grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (out_valid && out_ready) begin
      locked <= 1'b0;
      ptr    <= IdxW'(wrap_inc(32'(grant), NumSlv));
    end else if (out_valid) begin
      locked   <= 1'b1;
      lock_idx <= grant;
    end
  end

endmodule

// File: rtl/fifo_v3.sv
// Small register FIFO with optional fall-through; holds requester indices for routing.
module fifo_v3 #(
  parameter bit  FallThrough = 1'b0,
  parameter int  DataWidth   = 1,
  parameter int  Depth       = 4,
  parameter type dtype       = logic [DataWidth-1:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic test,
  output logic full,
  output logic empty,
  input  dtype data_in,
  input  logic push,
  output dtype data_out,
  input  logic pop
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthC = (PtrW+1)'(Depth);

  dtype            mem [Depth];
  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [PtrW:0]   cnt;
  logic            bypass, do_push, do_pop, unused_test;

  function automatic logic [PtrW-1:0] bump(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth-1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_test = test;
  // An empty fall-through FIFO hands the pushed word straight to a same-cycle pop.
  assign bypass   = FallThrough && (cnt == '0) && push && pop;
  assign full     = (cnt == DepthC);
  assign empty    = (cnt == '0) && !(FallThrough && push);
  assign data_out = (FallThrough && cnt == '0) ? data_in : mem[rd_ptr];
  assign do_push  = push && !full && !bypass;
  assign do_pop   = pop && !empty && !bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      cnt <= cnt + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/axi_lite_rr_mux.sv
// Shares one AXI4-Lite master among NumSlv requesters; responses are routed back via index FIFOs.
module axi_lite_rr_mux import axi_lite_rr_mux_pkg::*; #(
  parameter int NumSlv      = 2,
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 32,
  parameter int MaxWTrans   = 4,
  parameter int MaxRTrans   = 4,
  parameter bit FallThrough = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              test,
  axi_lite_rr_mux_if.slave  slv,
  axi_lite_rr_mux_if.master mst
);
  localparam int IdxW = (NumSlv > 1) ? $clog2(NumSlv) : 1;

  logic [IdxW-1:0]      aw_grant, ar_grant, w_head, b_head, r_head;
  logic [NumSlv-1:0]    aw_oh, ar_oh;
  logic                 w_full, w_empty, b_full, b_empty, r_full, r_empty;
  logic                 aw_open, ar_open, aw_fire, ar_fire, w_fire, b_fire, r_fire;
  logic                 w_route, b_route, r_route;
  logic [AddrWidth-1:0] aw_addr, ar_addr;
  logic [DataWidth-1:0] w_data;

  axi_lite_rr_arb #(.NumSlv(NumSlv), .IdxW(IdxW)) i_aw_arb (
    .clk, .rst_n, .valid(slv.aw_valid), .out_valid(mst.aw_valid[0]),
    .out_ready(mst.aw_ready[0]), .grant(aw_grant), .grant_oh(aw_oh)
  );

  axi_lite_rr_arb #(.NumSlv(NumSlv), .IdxW(IdxW)) i_ar_arb (
    .clk, .rst_n, .valid(slv.ar_valid), .out_valid(mst.ar_valid[0]),
    .out_ready(mst.ar_ready[0]), .grant(ar_grant), .grant_oh(ar_oh)
  );

  // Address channels: forward the granted requester only while its route FIFOs have room.
  assign aw_open         = rst_n & ~w_full & ~b_full;
  assign ar_open         = rst_n & ~r_full;
  assign aw_addr         = slv.aw_addr[aw_grant];
  assign ar_addr         = slv.ar_addr[ar_grant];
  assign mst.aw_addr[0]  = aw_addr;
  assign mst.aw_prot[0]  = slv.aw_prot[aw_grant];
  assign mst.aw_valid[0] = slv.aw_valid[aw_grant] & aw_open;
  assign slv.aw_ready    = aw_oh & {NumSlv{mst.aw_ready[0] & aw_open}};
  assign mst.ar_addr[0]  = ar_addr;
  assign mst.ar_prot[0]  = slv.ar_prot[ar_grant];
  assign mst.ar_valid[0] = slv.ar_valid[ar_grant] & ar_open;
  assign slv.ar_ready    = ar_oh & {NumSlv{mst.ar_ready[0] & ar_open}};
  assign aw_fire         = mst.aw_valid[0] & mst.aw_ready[0];
  assign ar_fire         = mst.ar_valid[0] & mst.ar_ready[0];

  // Data and response channels follow the FIFO heads.
  assign w_data          = slv.w_data[w_head];
  assign mst.w_data[0]   = w_data;
  assign mst.w_strb[0]   = slv.w_strb[w_head];
  assign mst.w_valid[0]  = slv.w_valid[w_head] & ~w_empty & rst_n;
  assign w_route         = mst.w_ready[0] & ~w_empty & rst_n;
  assign mst.b_ready[0]  = slv.b_ready[b_head] & ~b_empty & rst_n;
  assign b_route         = mst.b_valid[0] & ~b_empty & rst_n;
  assign mst.r_ready[0]  = slv.r_ready[r_head] & ~r_empty & rst_n;
  assign r_route         = mst.r_valid[0] & ~r_empty & rst_n;
  assign w_fire          = mst.w_valid[0] & mst.w_ready[0];
  assign b_fire          = mst.b_valid[0] & mst.b_ready[0];
  assign r_fire          = mst.r_valid[0] & mst.r_ready[0];

  always_comb begin
    slv.w_ready = '0;
    slv.b_valid = '0;
    slv.r_valid = '0;
    for (int i = 0; i < NumSlv; i++) begin
      slv.b_resp[i] = mst.b_resp[0];
      slv.r_data[i] = mst.r_data[0];
      slv.r_resp[i] = mst.r_resp[0];
    end
    slv.w_ready[w_head] = w_route;
    slv.b_valid[b_head] = b_route;
    slv.r_valid[r_head] = r_route;
  end

  fifo_v3 #(.FallThrough(FallThrough), .DataWidth(IdxW), .Depth(MaxWTrans)) i_w_fifo (
    .clk, .rst_n, .flush(1'b0), .test, .full(w_full), .empty(w_empty),
    .data_in(aw_grant), .push(aw_fire), .data_out(w_head), .pop(w_fire)
  );

  fifo_v3 #(.FallThrough(FallThrough), .DataWidth(IdxW), .Depth(MaxWTrans)) i_b_fifo (
    .clk, .rst_n, .flush(1'b0), .test, .full(b_full), .empty(b_empty),
    .data_in(aw_grant), .push(aw_fire), .data_out(b_head), .pop(b_fire)
  );

  fifo_v3 #(.FallThrough(FallThrough), .DataWidth(IdxW), .Depth(MaxRTrans)) i_r_fifo (
    .clk, .rst_n, .flush(1'b0), .test, .full(r_full), .empty(r_empty),
    .data_in(ar_grant), .push(ar_fire), .data_out(r_head), .pop(r_fire)
  );

endmodule

// File: tb/tb_axi_lite_rr_mux.sv
// Directed bench for axi_lite_rr_mux with two requesters and hand-computed expectations.
module tb_axi_lite_rr_mux;
  import axi_lite_rr_mux_pkg::*;

  localparam int NumSlv = 2;
  localparam int AW     = 32;
  localparam int DW     = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic test  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_lite_rr_mux_if #(.N(NumSlv), .AddrWidth(AW), .DataWidth(DW)) slv_bus ();
  axi_lite_rr_mux_if #(.N(1),      .AddrWidth(AW), .DataWidth(DW)) mst_bus ();

  axi_lite_rr_mux #(
    .NumSlv(NumSlv), .AddrWidth(AW), .DataWidth(DW),
    .MaxWTrans(4), .MaxRTrans(4), .FallThrough(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .test(test), .slv(slv_bus), .mst(mst_bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    slv_bus.aw_addr  = '0; slv_bus.aw_prot = '0; slv_bus.aw_valid = '0;
    slv_bus.w_data   = '0; slv_bus.w_strb  = '0; slv_bus.w_valid  = '0;
    slv_bus.b_ready  = '0;
    slv_bus.ar_addr  = '0; slv_bus.ar_prot = '0; slv_bus.ar_valid = '0;
    slv_bus.r_ready  = '0;
    mst_bus.aw_ready = '0; mst_bus.w_ready = '0;
    mst_bus.b_resp   = '0; mst_bus.b_valid = '0;
    mst_bus.ar_ready = '0;
    mst_bus.r_data   = '0; mst_bus.r_resp  = '0; mst_bus.r_valid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic busy_inputs();
    slv_bus.aw_valid = 2'b11; slv_bus.w_valid = 2'b11; slv_bus.b_ready = 2'b11;
    slv_bus.ar_valid = 2'b11; slv_bus.r_ready = 2'b11;
    mst_bus.aw_ready = 1'b1;  mst_bus.w_ready = 1'b1;  mst_bus.b_valid = 1'b1;
    mst_bus.ar_ready = 1'b1;  mst_bus.r_valid = 1'b1;
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_mst_aw_valid"}, mst_bus.aw_valid, 0);
    chk({pfx, "_slv_aw_ready"}, slv_bus.aw_ready, 0);
    chk({pfx, "_mst_w_valid"},  mst_bus.w_valid,  0);
    chk({pfx, "_slv_w_ready"},  slv_bus.w_ready,  0);
    chk({pfx, "_slv_b_valid"},  slv_bus.b_valid,  0);
    chk({pfx, "_mst_b_ready"},  mst_bus.b_ready,  0);
    chk({pfx, "_mst_ar_valid"}, mst_bus.ar_valid, 0);
    chk({pfx, "_slv_ar_ready"}, slv_bus.ar_ready, 0);
    chk({pfx, "_slv_r_valid"},  slv_bus.r_valid,  0);
    chk({pfx, "_mst_r_ready"},  mst_bus.r_ready,  0);
  endtask

  initial begin
    int cnt0;
    int cnt1;

    // Reset state: every handshake output low even with all inputs active.
    idle_inputs();
    busy_inputs();
    settle();
    chk_quiet("rst");
    do_reset();

    // Single write from requester 0, B returned three cycles after W.
    slv_bus.aw_addr[0] = 32'h10;  slv_bus.aw_valid = 2'b01;
    slv_bus.w_data[0]  = 32'hDEADBEEF; slv_bus.w_strb[0] = 4'hF; slv_bus.w_valid = 2'b01;
    mst_bus.aw_ready = 1'b1; mst_bus.w_ready = 1'b1;
    settle();
    chk("wr_aw_valid", mst_bus.aw_valid, 1);
    chk("wr_aw_addr",  mst_bus.aw_addr[0], 32'h10);
    chk("wr_aw_ready", slv_bus.aw_ready, 2'b01);
    chk("wr_w_early",  mst_bus.w_valid, 0);
    step();
    slv_bus.aw_valid = 2'b00;
    settle();
    chk("wr_w_valid", mst_bus.w_valid, 1);
    chk("wr_w_data",  mst_bus.w_data[0], 32'hDEADBEEF);
    chk("wr_w_strb",  mst_bus.w_strb[0], 4'hF);
    chk("wr_w_ready", slv_bus.w_ready, 2'b01);
    step();
    slv_bus.w_valid = 2'b00; slv_bus.b_ready = 2'b01;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("wr_b_wait%0d", k), slv_bus.b_valid, 2'b00);
      step();
    end
    mst_bus.b_valid = 1'b1; mst_bus.b_resp = RESP_OKAY;
    settle();
    chk("wr_b_valid", slv_bus.b_valid, 2'b01);
    chk("wr_b_resp",  slv_bus.b_resp[0], RESP_OKAY);
    chk("wr_b_ready", mst_bus.b_ready, 1);
    step();
    settle();
    chk("wr_b_drained", mst_bus.b_ready, 0);
    mst_bus.b_valid = 1'b0;
    do_reset();

    // Fairness: both requesters always valid, W and B drained every cycle.
    slv_bus.aw_addr[0] = 32'h100; slv_bus.aw_addr[1] = 32'h200;
    slv_bus.aw_valid = 2'b11; slv_bus.w_valid = 2'b11; slv_bus.b_ready = 2'b11;
    mst_bus.aw_ready = 1'b1;  mst_bus.w_ready = 1'b1;  mst_bus.b_valid = 1'b1;
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk($sformatf("fair_grant%0d", k), slv_bus.aw_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("fair_addr%0d", k), mst_bus.aw_addr[0], (k % 2 == 0) ? 32'h100 : 32'h200);
      if (slv_bus.aw_ready == 2'b01) cnt0++;
      else if (slv_bus.aw_ready == 2'b10) cnt1++;
      step();
    end
    chk("fair_cnt0", cnt0, 4);
    chk("fair_cnt1", cnt1, 4);
    do_reset();

    // Backpressure lock: pointer already favours requester 1 once it raises valid.
    slv_bus.aw_addr[0] = 32'h40; slv_bus.aw_addr[1] = 32'h80;
    slv_bus.aw_valid = 2'b01; mst_bus.aw_ready = 1'b1;
    settle();
    chk("lock_pre_ready", slv_bus.aw_ready, 2'b01);
    step();
    mst_bus.aw_ready = 1'b0;
    settle();
    chk("lock_valid", mst_bus.aw_valid, 1);
    chk("lock_addr0", mst_bus.aw_addr[0], 32'h40);
    step();
    slv_bus.aw_valid = 2'b11;
    for (int k = 1; k < 5; k++) begin
      settle();
      chk($sformatf("lock_addr%0d", k), mst_bus.aw_addr[0], 32'h40);
      chk($sformatf("lock_ready%0d", k), slv_bus.aw_ready, 2'b00);
      step();
    end
    mst_bus.aw_ready = 1'b1;
    settle();
    chk("lock_release_ready", slv_bus.aw_ready, 2'b01);
    chk("lock_release_addr",  mst_bus.aw_addr[0], 32'h40);
    step();
    slv_bus.aw_valid = 2'b10;
    settle();
    chk("lock_next_ready", slv_bus.aw_ready, 2'b10);
    chk("lock_next_addr",  mst_bus.aw_addr[0], 32'h80);
    do_reset();

    // Full stall: four reads fill the R route FIFO, the fifth waits for an R handshake.
    slv_bus.ar_addr[0] = 32'h500; slv_bus.ar_valid = 2'b01; mst_bus.ar_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("full_ar%0d", k), slv_bus.ar_ready, 2'b01);
      step();
    end
    settle();
    chk("full_stall_ready", slv_bus.ar_ready, 2'b00);
    chk("full_stall_valid", mst_bus.ar_valid, 0);
    step();
    mst_bus.r_valid = 1'b1; mst_bus.r_data = 32'h1; mst_bus.r_resp = RESP_OKAY;
    slv_bus.r_ready = 2'b01;
    settle();
    chk("full_r_valid",    slv_bus.r_valid, 2'b01);
    chk("full_same_cycle", slv_bus.ar_ready, 2'b00);
    step();
    mst_bus.r_valid = 1'b0;
    settle();
    chk("full_fifth_ready", slv_bus.ar_ready, 2'b01);
    do_reset();

    // Ordering: reads return on the master in AR-grant order 0 then 1.
    slv_bus.ar_addr[0] = 32'h100; slv_bus.ar_addr[1] = 32'h200;
    slv_bus.ar_valid = 2'b11; mst_bus.ar_ready = 1'b1;
    settle();
    chk("ord_ar0_ready", slv_bus.ar_ready, 2'b01);
    chk("ord_ar0_addr",  mst_bus.ar_addr[0], 32'h100);
    step();
    slv_bus.ar_valid = 2'b10;
    settle();
    chk("ord_ar1_ready", slv_bus.ar_ready, 2'b10);
    chk("ord_ar1_addr",  mst_bus.ar_addr[0], 32'h200);
    step();
    slv_bus.ar_valid = 2'b00; slv_bus.r_ready = 2'b11;
    mst_bus.r_valid = 1'b1; mst_bus.r_data = 32'hA5; mst_bus.r_resp = RESP_OKAY;
    settle();
    chk("ord_r0_valid", slv_bus.r_valid, 2'b01);
    chk("ord_r0_data",  slv_bus.r_data[0], 32'hA5);
    step();
    mst_bus.r_data = 32'h5A; mst_bus.r_resp = RESP_SLVERR;
    settle();
    chk("ord_r1_valid", slv_bus.r_valid, 2'b10);
    chk("ord_r1_data",  slv_bus.r_data[1], 32'h5A);
    chk("ord_r1_resp",  slv_bus.r_resp[1], RESP_SLVERR);
    step();
    settle();
    chk("ord_empty_ready", mst_bus.r_ready, 0);
    chk("ord_empty_valid", slv_bus.r_valid, 2'b00);
    do_reset();

    // Reset with two writes outstanding (requester 1 then 0, leaving aw_ptr at 1).
    slv_bus.aw_addr[1] = 32'h300; slv_bus.aw_valid = 2'b10; mst_bus.aw_ready = 1'b1;
    settle();
    chk("rst_wr1_ready", slv_bus.aw_ready, 2'b10);
    step();
    slv_bus.aw_addr[0] = 32'h400; slv_bus.aw_valid = 2'b01;
    settle();
    chk("rst_wr0_ready", slv_bus.aw_ready, 2'b01);
    step();
    busy_inputs();
    settle();
    chk("rst_pre_w_valid", mst_bus.w_valid, 1);
    chk("rst_pre_grant",   slv_bus.aw_ready, 2'b10);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_mid");
    step();
    rst_n = 1'b1;
    settle();
    chk("rst_post_w_valid", mst_bus.w_valid, 0);
    chk("rst_post_b_valid", slv_bus.b_valid, 2'b00);
    chk("rst_post_r_valid", slv_bus.r_valid, 2'b00);
    chk("rst_post_aw_grant", slv_bus.aw_ready, 2'b01);
    chk("rst_post_ar_grant", slv_bus.ar_ready, 2'b01);
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
